// File: rtl/scan_sequencer.sv
// Autonomous scan-chain shifter: shifts up to 16 bits LSB first through the DUT scan
// chain with a programmable scan-clock half period, capturing scan-out before each rise.
module scan_sequencer #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  len,
  input  logic [15:0] tx_data,
  output logic [15:0] rx_data,
  output logic        busy,
  output logic        done,
  output logic        scan_clk,
  output logic        scan_en,
  output logic        scan_in,
  input  logic        scan_out
);

  localparam logic [7:0] PHASE_LOAD = 8'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    TAIL
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] tx_reg, tx_next;
  logic [3:0]  bit_idx_reg, bit_idx_next;
  logic [3:0]  remaining_reg, remaining_next;
  logic [7:0]  phase_reg, phase_next;
  logic        last_reg, last_next;
  logic [15:0] rx_reg, rx_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        scan_clk_reg, scan_clk_next;
  logic        scan_en_reg, scan_en_next;
  logic        scan_in_reg, scan_in_next;
  logic        rx_clear;
  logic        capture_en;
  logic        phase_end;

  assign phase_end = (phase_reg == 8'd0);

  always_comb begin
    state_next     = state_reg;
    tx_next        = tx_reg;
    bit_idx_next   = bit_idx_reg;
    remaining_next = remaining_reg;
    phase_next     = phase_reg;
    last_next      = last_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    scan_clk_next  = scan_clk_reg;
    scan_en_next   = scan_en_reg;
    scan_in_next   = scan_in_reg;
    rx_clear       = 1'b0;
    capture_en     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next     = SETUP;
          tx_next        = tx_data;
          bit_idx_next   = 4'd0;
          remaining_next = len;
          last_next      = (len == 4'd0);
          phase_next     = PHASE_LOAD;
          rx_clear       = 1'b1;
          busy_next      = 1'b1;
          scan_en_next   = 1'b1;
          scan_in_next   = tx_data[0];
          scan_clk_next  = 1'b0;
        end
      end

      SETUP: begin
        if (phase_end) begin
          // Sample scan_out on the same edge that raises scan_clk: the value
          // seen here is the one the DUT presented before the rising edge.
          capture_en    = 1'b1;
          scan_clk_next = 1'b1;
          phase_next    = PHASE_LOAD;
          state_next    = HIGH;
        end else begin
          phase_next = phase_reg - 8'd1;
        end
      end

      HIGH: begin
        if (phase_end) begin
          scan_clk_next = 1'b0;
          phase_next    = PHASE_LOAD;
          if (last_reg) begin
            state_next = TAIL;
          end else begin
            tx_next        = {1'b0, tx_reg[15:1]};
            scan_in_next   = tx_reg[1];
            bit_idx_next   = bit_idx_reg + 4'd1;
            remaining_next = remaining_reg - 4'd1;
            last_next      = (remaining_reg == 4'd1);
            state_next     = SETUP;
          end
        end else begin
          phase_next = phase_reg - 8'd1;
        end
      end

      TAIL: begin
        if (phase_end) begin
          scan_en_next = 1'b0;
          scan_in_next = 1'b0;
          busy_next    = 1'b0;
          done_next    = 1'b1;
          state_next   = IDLE;
        end else begin
          phase_next = phase_reg - 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort wins over every in-flight transition; the partial capture is kept.
    if (abort && (state_reg != IDLE)) begin
      state_next    = IDLE;
      scan_clk_next = 1'b0;
      scan_en_next  = 1'b0;
      scan_in_next  = 1'b0;
      busy_next     = 1'b0;
      done_next     = 1'b0;
      capture_en    = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rx
      assign rx_next[gi] = rx_clear ? 1'b0 :
                           (capture_en && (bit_idx_reg == 4'(gi))) ? scan_out :
                           rx_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      tx_reg        <= '0;
      bit_idx_reg   <= '0;
      remaining_reg <= '0;
      phase_reg     <= '0;
      last_reg      <= 1'b0;
      rx_reg        <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      scan_clk_reg  <= 1'b0;
      scan_en_reg   <= 1'b0;
      scan_in_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tx_reg        <= tx_next;
      bit_idx_reg   <= bit_idx_next;
      remaining_reg <= remaining_next;
      phase_reg     <= phase_next;
      last_reg      <= last_next;
      rx_reg        <= rx_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      scan_clk_reg  <= scan_clk_next;
      scan_en_reg   <= scan_en_next;
      scan_in_reg   <= scan_in_next;
    end
  end

  assign rx_data  = rx_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign scan_clk = scan_clk_reg;
  assign scan_en  = scan_en_reg;
  assign scan_in  = scan_in_reg;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: vector table, hand-written corner sequences
// and random transactions checked against a rule-level model of the shift.
module tb_scan_sequencer;

  localparam int HP = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [3:0]  len;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic        busy, done, scan_clk, scan_en, scan_in;
  logic        scan_out;

  logic [15:0] rx1;
  logic        busy1, done1, scan_clk1, scan_en1, scan_in1;

  int n_checks = 0;
  int n_fail   = 0;

  scan_sequencer #(.HALF_PERIOD(HP)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .len(len),
    .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
    .scan_clk(scan_clk), .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out)
  );

  scan_sequencer #(.HALF_PERIOD(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .len(len),
    .tx_data(tx_data), .rx_data(rx1), .busy(busy1), .done(done1),
    .scan_clk(scan_clk1), .scan_en(scan_en1), .scan_in(scan_in1), .scan_out(scan_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Rule-level expectations: n bits, (2n+1) half periods, captured bits masked to n.
  function automatic logic [15:0] model_rx(input logic [3:0] l, input logic [15:0] so);
    logic [16:0] m;
    m = (17'd1 << (int'(l) + 1)) - 17'd1;
    return so & m[15:0];
  endfunction

  function automatic int model_cycles(input logic [3:0] l);
    return (2 * (int'(l) + 1) + 1) * HP;
  endfunction

  // Caller must be at a negedge. Drives start now; scan_out for bit k is so_pat[k].
  task automatic run_shift(input string tag, input logic [3:0] l, input logic [15:0] tx,
                           input logic [15:0] so_pat, input logic [15:0] exp_rx,
                           input int exp_cyc, input int exp_pulses,
                           input int repulse_rise, input bit chain);
    int idx, rises, hi_run, lo_run, busy_cnt, bad_run, bad_in, bad_en, done_idx;
    logic prev_clk, prev_in, got_done;
    logic [15:0] rx_at_done;
    logic [2:0]  end_lines;
    start = 1'b1; abort = 1'b0; len = l; tx_data = tx; scan_out = so_pat[0];
    @(negedge clk);
    start = 1'b0;
    idx = 0; rises = 0; hi_run = 0; lo_run = 0; busy_cnt = 0;
    bad_run = 0; bad_in = 0; bad_en = 0; done_idx = -1;
    prev_clk = 1'b0; prev_in = scan_in; got_done = 1'b0;
    rx_at_done = 'x; end_lines = 'x;
    while (!got_done && idx < 400) begin
      if (done) begin
        got_done   = 1'b1;
        done_idx   = idx;
        rx_at_done = rx_data;
        end_lines  = {busy, scan_en, scan_in};
        if (scan_clk || lo_run != HP) bad_run++;
      end else begin
        if (busy) busy_cnt++;
        if (!scan_en) bad_en++;
        if (idx > 0 && scan_in !== prev_in && !(prev_clk && !scan_clk)) bad_in++;
        if (scan_clk && !prev_clk) begin
          if (lo_run != HP) bad_run++;
          if (rises < 16 && scan_in !== tx[rises]) bad_in++;
          rises++;
          hi_run = 1;
          if (rises == repulse_rise) begin
            start = 1'b1; len = 4'd15; tx_data = ~tx;
          end
        end else if (!scan_clk && prev_clk) begin
          if (hi_run != HP) bad_run++;
          lo_run = 1;
        end else if (scan_clk) begin
          hi_run++;
        end else begin
          lo_run++;
        end
        if (rises < 16) scan_out = so_pat[rises];
        prev_clk = scan_clk;
        prev_in  = scan_in;
        @(negedge clk);
        start = 1'b0;
        idx++;
      end
    end
    check({tag, " done_seen"}, 32'(got_done), 32'd1);
    check({tag, " latency"}, done_idx, exp_cyc);
    check({tag, " pulses"}, rises, exp_pulses);
    check({tag, " rx_data"}, 32'(rx_at_done), 32'(exp_rx));
    check({tag, " busy_cycles"}, busy_cnt, exp_cyc);
    check({tag, " phase_len_errs"}, bad_run, 0);
    check({tag, " scan_in_errs"}, bad_in, 0);
    check({tag, " scan_en_errs"}, bad_en, 0);
    check({tag, " end_lines"}, 32'(end_lines), 32'd0);
    if (!chain) begin
      @(negedge clk);
      check({tag, " done_width"}, 32'(done), 32'd0);
      check({tag, " rx_hold"}, 32'(rx_data), 32'(exp_rx));
    end
    $display("txn %s len=%0d tx=%h so=%h rx=%h cycles=%0d pulses=%0d",
             tag, l, tx, so_pat, rx_at_done, done_idx, rises);
  endtask

  typedef struct {
    logic [3:0]  len;
    logic [15:0] tx;
    logic [15:0] so;
    logic [15:0] exp_rx;
    int          exp_cyc;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int idx, r1, d1, cnt, rises;
    logic pc1, pc, fired;
    logic [15:0] rx1_at;
    logic [3:0]  rl;
    logic [15:0] rtx, rso;
    bit chain;

    vecs[0] = '{4'd3,  16'h000A, 16'h000B, 16'h000B, 36,  4};
    vecs[1] = '{4'd15, 16'hFFFF, 16'h0000, 16'h0000, 132, 16};
    vecs[2] = '{4'd0,  16'h0001, 16'h0001, 16'h0001, 12,  1};
    vecs[3] = '{4'd7,  16'h00A5, 16'hFF3C, 16'h003C, 68,  8};
    vecs[4] = '{4'd15, 16'h1234, 16'hBEEF, 16'hBEEF, 132, 16};

    // Reset held 3 cycles with start asserted alongside it.
    reset = 1'b1; start = 1'b1; abort = 1'b0; len = 4'd0; tx_data = 16'h0001; scan_out = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({rx_data, busy, done, scan_clk, scan_en, scan_in}), 32'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", 32'({rx_data, busy, done, scan_clk, scan_en, scan_in}), 32'd0);

    // HALF_PERIOD=1 instance: 3 bits, scan_out high.
    len = 4'd2; tx_data = 16'h0005; scan_out = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0; r1 = 0; d1 = -1; pc1 = 1'b0; rx1_at = 'x;
    while (d1 < 0 && idx < 40) begin
      if (scan_clk1 && !pc1) r1++;
      if (done1) begin
        d1 = idx; rx1_at = rx1;
      end else begin
        pc1 = scan_clk1;
        @(negedge clk);
        idx++;
      end
    end
    check("hp1 latency", d1, 7);
    check("hp1 pulses", r1, 3);
    check("hp1 rx_data", 32'(rx1_at), 32'h0007);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("hp1 abort_main_busy", 32'({busy, scan_en, scan_clk}), 32'd0);

    foreach (vecs[i])
      run_shift($sformatf("vec%0d", i), vecs[i].len, vecs[i].tx, vecs[i].so,
                vecs[i].exp_rx, vecs[i].exp_cyc, vecs[i].exp_pulses, -1, 1'b0);

    // Start re-pulsed during the high phase of bit 2 must be ignored.
    run_shift("repulse", 4'd7, 16'h0033, 16'h00C9, 16'h00C9, 68, 8, 3, 1'b0);

    // Abort in SETUP of bit 5.
    len = 4'd15; tx_data = 16'h5A5A; scan_out = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0; pc = 1'b0; fired = 1'b0;
    for (int k = 0; k < 300 && !fired; k++) begin
      if (scan_clk && !pc) rises++;
      if (rises == 5 && !scan_clk && pc) begin
        abort = 1'b1; fired = 1'b1;
      end
      pc = scan_clk;
      @(negedge clk);
    end
    abort = 1'b0;
    check("abort fired", 32'(fired), 32'd1);
    check("abort outputs", 32'({busy, done, scan_clk, scan_en, scan_in}), 32'd0);
    check("abort rx_data", 32'(rx_data), 32'h001F);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("abort quiet", cnt, 0);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_with_start busy", 32'(busy), 32'd0);
    $display("txn abort len=15 rx=%h", rx_data);

    // Reset during bit 3 of a 16-bit shift.
    len = 4'd15; tx_data = 16'hFFFF; scan_out = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0; pc = 1'b0; fired = 1'b0;
    for (int k = 0; k < 300 && !fired; k++) begin
      if (scan_clk && !pc) rises++;
      if (rises == 4) begin
        reset = 1'b1; fired = 1'b1;
      end
      pc = scan_clk;
      @(negedge clk);
    end
    reset = 1'b0;
    check("midreset fired", 32'(fired), 32'd1);
    check("midreset outputs", 32'({rx_data, busy, done, scan_clk, scan_en, scan_in}), 32'd0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("midreset quiet", cnt, 0);
    $display("txn midreset rx=%h", rx_data);
    run_shift("after_reset", 4'd0, 16'h0001, 16'h0001, 16'h0001, 12, 1, -1, 1'b0);

    // Random transactions, some started in the done cycle of the previous one.
    for (int i = 0; i < 12; i++) begin
      rl    = 4'($urandom_range(0, 15));
      rtx   = 16'($urandom);
      rso   = 16'($urandom);
      chain = (i != 11) && ($urandom_range(0, 1) == 1);
      run_shift($sformatf("rand%0d", i), rl, rtx, rso, model_rx(rl, rso),
                model_cycles(rl), int'(rl) + 1, -1, chain);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Autonomous scan-path shifter that drives the DUT scan chain (scan clock, scan enable, scan-in) and captures scan-out, so the host no longer bit-bangs the chain one register write per edge. It sits between the host register interface and the DUT scan pins. The host loads a word of up to 16 bits and a length, then pulses start. The block generates the scan clock pulses and returns the captured bits with a busy/done handshake.

Parameters:
HALF_PERIOD, 4, clk cycles per scan-clock phase (low or high); legal range 1..255.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; accepted only in IDLE
abort  input  1  abandon current shift; takes priority over all except reset
len  input  4  bits to shift minus one (0 -> 1 bit, 15 -> 16 bits); sampled with start
tx_data  input  16  bits to scan in, LSB first; sampled with start
rx_data  output  16  captured scan-out bits; first captured bit in bit 0
busy  output  1  high from acceptance edge until return to IDLE
done  output  1  one-cycle pulse on normal completion
scan_clk  output  1  DUT scan clock (unbuffered; clock-net buffering is outside this block)
scan_en  output  1  DUT scan enable
scan_in  output  1  serial data into DUT chain
scan_out  input  1  serial data from DUT chain, same clock domain

Behaviour:
- Reset values: rx_data=0, busy=0, done=0, scan_clk=0, scan_en=0, scan_in=0, state IDLE.
- Internals: tx shift register (16), bit index (4), remaining-bit counter, phase counter (8, counts HALF_PERIOD-1 down to 0), registered last-bits flag.
- States:
  - IDLE: scan_en=0, scan_clk=0, busy=0.
  - SETUP: scan_clk=0, scan_in = current bit, HALF_PERIOD cycles.
  - HIGH: scan_clk=1, HALF_PERIOD cycles.
  - TAIL: scan_clk=0, scan_en still 1, HALF_PERIOD cycles.
- IDLE with start=1: on that edge load tx_data and len, clear rx_data to 0, busy=1, scan_en=1, scan_in=tx_data[0], scan_clk=0, go to SETUP.
- SETUP, final phase cycle: on the edge, rx_data[bit index] <= scan_out (the value before the rising scan edge), scan_clk<=1, go to HIGH.
- HIGH, final phase cycle:
  - if bits remain: scan_clk<=0, shift tx right, scan_in<=next bit, bit index +1, go to SETUP;
  - else: scan_clk<=0, go to TAIL.
- TAIL, final phase cycle: scan_en<=0, scan_in<=0, busy<=0, done<=1 for exactly one cycle, go to IDLE.
- Timing: n = len+1 bits; start edge to done-high edge = (2n+1)*HALF_PERIOD cycles. scan_in is stable for a full SETUP phase before every scan_clk rise and changes only on a scan_clk fall.
- rx_data bits at index >= n remain 0. rx_data holds its value in IDLE until the next accepted start.
- start while busy (including the done cycle's edge, where state is already IDLE) behaves as follows:
  - while not IDLE: ignored, with no queuing;
  - in IDLE: accepted, and back-to-back starts are legal.
- abort in any non-IDLE state: next edge -> IDLE, scan_clk=0, scan_en=0, scan_in=0, busy=0, done stays 0, rx_data keeps the partial capture. abort in IDLE: no effect. abort together with start in IDLE: start ignored.
- reset mid-operation: all outputs to reset values on that edge, including rx_data=0. No done pulse.
- HALF_PERIOD=1: phases are single cycles, and the same rules apply.

Test Plan:
1. Hold reset 3 cycles mid-idle, then release -> all outputs 0. start in the same cycle as reset is ignored.
2. HALF_PERIOD=4, len=3, tx_data=16'h000A; bench drives scan_out 1,1,0,1 for successive bits -> scan_in 0,1,0,1 at each scan_clk rise; exactly 4 scan_clk pulses, each 4 high / 4 low; done 36 cycles after start; rx_data=16'h000B.
3. len=15, tx_data=16'hFFFF, scan_out tied 0 -> 16 pulses; scan_in=1 throughout shifting; done at cycle 132; rx_data=16'h0000; busy high for exactly 132 cycles.
4. len=7 with start re-pulsed during HIGH of bit 2 -> ignored; exactly 8 pulses; a single done.
5. Abort during SETUP of bit 5 (len=15, scan_out tied 1) -> next cycle IDLE, scan_clk=0, scan_en=0; done never pulses; rx_data=16'h001F.
6. Reset asserted during bit 3 of a 16-bit shift -> outputs reset that edge. A following start with len=0, tx=1, scan_out=1 gives a single pulse, done at cycle 12, rx_data=16'h0001.
